// File: rtl/rom_arbiter_if.sv
// Purpose: single-beat read bus between a requester and a ROM-style responder.
// Latency: none of its own; data/ready/err are combinational from the responder.
// Backpressure: the requester holds valid/addr stable until ready is seen.
// Signals: addr/valid flow requester->responder; data/ready/err flow back.
// The master modport omits err because the memory slave never reports errors.
interface rom_arbiter_if;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic        err;

  // Requester side (the arbiter's view of the memory slave).
  modport master (
    output addr,
    output valid,
    input  data,
    input  ready
  );

  // Responder side (the arbiter's view of each core port).
  modport slave (
    input  addr,
    input  valid,
    output data,
    output ready,
    output err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Purpose: round-robin arbiter sharing one ROM-style read port between fetch (m0) and load (m1).
// Latency: zero cycles with a ready slave; otherwise the slave's wait states, capped at TIMEOUT.
// Backpressure: a granted master is locked until s.ready or the watchdog fires; the other sees ready=0.
// Ports: clk, reset_n (sync, active-low); m0/m1 core-side request ports; s memory-side port.
// Params: TIMEOUT stall cycles before a locked transaction ends with err; ERR_DATA returned then.
module rom_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset_n,
  rom_arbiter_if.slave  m0,
  rom_arbiter_if.slave  m1,
  rom_arbiter_if.master s
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]    state;
  logic          last;
  logic [CW-1:0] cnt;

  logic any_req;
  logic win;
  logic sel;
  logic locked;
  logic busy;
  logic timed_out;
  logic finish;

  always_comb begin
    any_req = m0.valid | m1.valid;
    // On a tie the master that did not complete last wins; otherwise whoever asks.
    if (m0.valid && m1.valid) win = ~last;
    else                      win = m1.valid;

    locked = (state == LOCK0) || (state == LOCK1);

    // sel picks the master that owns the slave port this cycle. It rests on m0
    // when idle or in reset so s.addr defaults to m0's address.
    sel = 1'b0;
    if (reset_n) begin
      case (state)
        LOCK0:   sel = 1'b0;
        LOCK1:   sel = 1'b1;
        default: sel = win;
      endcase
    end

    busy      = reset_n && (locked || any_req);
    // A slave response in the same cycle as the deadline takes priority.
    timed_out = reset_n && locked && !s.ready && (cnt == CW'(TIMEOUT));
    finish    = busy && (s.ready || timed_out);
  end

  assign s.valid = busy;
  assign s.addr  = sel ? m1.addr : m0.addr;

  assign m0.ready = finish && !sel;
  assign m0.err   = timed_out && !sel;
  assign m0.data  = (timed_out && !sel) ? ERR_DATA : s.data;

  assign m1.ready = finish && sel;
  assign m1.err   = timed_out && sel;
  assign m1.data  = (timed_out && sel) ? ERR_DATA : s.data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (s.ready) begin
              last <= win;
            end else begin
              state <= win ? LOCK1 : LOCK0;
              cnt   <= CW'(1);
            end
          end
        end
        LOCK0, LOCK1: begin
          // The locked master's valid is deliberately ignored here; a master that
          // drops it early still gets its transaction run to completion.
          if (s.ready || timed_out) begin
            last  <= (state == LOCK1);
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Purpose: self-checking bench for rom_arbiter with TIMEOUT=4 and a synthetic ROM slave.
// Latency: expects zero-wait completions and locked completions at the slave's ready cycle.
// Backpressure: the bench drives s.ready per cycle to model waits, hangs and races.
module tb_rom_arbiter;

  localparam logic [31:0] ERR_DATA = 32'h0000_0013;

  typedef struct packed {
    logic        m;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  rom_arbiter_if m0_bus ();
  rom_arbiter_if m1_bus ();
  rom_arbiter_if s_bus ();

  rom_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR_DATA)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a fixed function of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0] ^ 16'h5A5A};
  endfunction

  always_comb s_bus.data = rom_word(s_bus.addr);
  assign s_bus.err = 1'b0;

  // Scoreboard monitor: every completion seen on a master port pops one expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic        gm;
    logic [31:0] gd;
    logic        ge;
    if (m0_bus.ready && m1_bus.ready) begin
      checks++;
      failures++;
      $display("FAIL both_ready: m0_ready=1 m1_ready=1, required at most one");
    end else if (m0_bus.ready || m1_bus.ready) begin
      gm = m1_bus.ready;
      gd = gm ? m1_bus.data : m0_bus.data;
      ge = gm ? m1_bus.err : m0_bus.err;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: master=%0d data=%h err=%0d, none expected", gm, gd, ge);
      end else begin
        e = sb.pop_front();
        if ({gm, gd, ge} !== {e.m, e.d, e.e}) begin
          failures++;
          $display("FAIL completion: got master=%0d data=%h err=%0d, required master=%0d data=%h err=%0d",
                   gm, gd, ge, e.m, e.d, e.e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL %s_drained: %0d completions outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    m0_bus.valid  = 1'b1;
    m0_bus.addr   = 32'h40;
    m1_bus.valid  = 1'b1;
    m1_bus.addr   = 32'h80;
    s_bus.ready   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({s_bus.valid, m0_bus.ready, m1_bus.ready, m0_bus.err, m1_bus.err} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs: s_valid/m0_rdy/m1_rdy/m0_err/m1_err=%b, required 00000",
                 {s_bus.valid, m0_bus.ready, m1_bus.ready, m0_bus.err, m1_bus.err});
      end
      checks++;
      if (s_bus.addr !== 32'h40) begin
        failures++;
        $display("FAIL reset_s_addr: got %h, required %h", s_bus.addr, 32'h40);
      end
      checks++;
      if (m0_bus.data !== rom_word(32'h40) || m1_bus.data !== rom_word(32'h40)) begin
        failures++;
        $display("FAIL reset_data: m0=%h m1=%h, required %h", m0_bus.data, m1_bus.data, rom_word(32'h40));
      end
    end
    cyc();
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    reset_n      = 1'b1;
    cyc();
    check_drained("reset");
  endtask

  task automatic test_zero_wait();
    s_bus.ready  = 1'b1;
    m0_bus.addr  = 32'h10;
    m0_bus.valid = 1'b1;
    sb.push_back('{m: 1'b0, d: rom_word(32'h10), e: 1'b0});
    @(negedge clk);
    checks++;
    if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0 || s_bus.addr !== 32'h10) begin
      failures++;
      $display("FAIL zero_wait: m0_rdy=%b m1_rdy=%b s_addr=%h, required 1 0 00000010",
               m0_bus.ready, m1_bus.ready, s_bus.addr);
    end
    cyc();
    m0_bus.valid = 1'b0;
    cyc();
    check_drained("zero_wait");
  endtask

  task automatic test_round_robin();
    logic [31:0] a;
    reset_n = 1'b0;
    cyc();
    reset_n      = 1'b1;
    s_bus.ready  = 1'b1;
    m0_bus.addr  = 32'h20;
    m1_bus.addr  = 32'h30;
    m0_bus.valid = 1'b1;
    m1_bus.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h20 : 32'h30;
      sb.push_back('{m: (i % 2 == 1), d: rom_word(a), e: 1'b0});
      @(negedge clk);
      checks++;
      if (s_bus.addr !== a) begin
        failures++;
        $display("FAIL rr_s_addr[%0d]: got %h, required %h", i, s_bus.addr, a);
      end
      cyc();
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    cyc();
    check_drained("round_robin");
  endtask

  task automatic test_wait_lock();
    s_bus.ready  = 1'b0;
    m1_bus.addr  = 32'h34;
    m1_bus.valid = 1'b1;
    sb.push_back('{m: 1'b1, d: rom_word(32'h34), e: 1'b0});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        m0_bus.addr  = 32'h18;
        m0_bus.valid = 1'b1;
      end
      if (c == 3) s_bus.ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_bus.addr !== 32'h34 || s_bus.valid !== 1'b1 || m0_bus.ready !== 1'b0) begin
        failures++;
        $display("FAIL lock_hold[%0d]: s_addr=%h s_valid=%b m0_rdy=%b, required 00000034 1 0",
                 c, s_bus.addr, s_bus.valid, m0_bus.ready);
      end
      checks++;
      if (m1_bus.ready !== (c == 3) || m1_bus.err !== 1'b0) begin
        failures++;
        $display("FAIL lock_m1_ready[%0d]: rdy=%b err=%b, required %b 0", c, m1_bus.ready, m1_bus.err, c == 3);
      end
      cyc();
    end
    m1_bus.valid = 1'b0;
    sb.push_back('{m: 1'b0, d: rom_word(32'h18), e: 1'b0});
    @(negedge clk);
    checks++;
    if (m0_bus.ready !== 1'b1 || s_bus.addr !== 32'h18) begin
      failures++;
      $display("FAIL lock_next_grant: m0_rdy=%b s_addr=%h, required 1 00000018", m0_bus.ready, s_bus.addr);
    end
    cyc();
    m0_bus.valid = 1'b0;
    cyc();
    check_drained("wait_lock");
  endtask

  task automatic test_timeout();
    s_bus.ready  = 1'b0;
    m0_bus.addr  = 32'h24;
    m0_bus.valid = 1'b1;
    sb.push_back('{m: 1'b0, d: ERR_DATA, e: 1'b1});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m0_bus.ready !== (c == 4) || m0_bus.err !== (c == 4) || s_bus.valid !== 1'b1) begin
        failures++;
        $display("FAIL timeout[%0d]: rdy=%b err=%b s_valid=%b, required %b %b 1",
                 c, m0_bus.ready, m0_bus.err, s_bus.valid, c == 4, c == 4);
      end
      cyc();
    end
    // Back in IDLE: a fresh request from m1 completes in its own cycle.
    m0_bus.valid = 1'b0;
    m1_bus.addr  = 32'h38;
    m1_bus.valid = 1'b1;
    s_bus.ready  = 1'b1;
    sb.push_back('{m: 1'b1, d: rom_word(32'h38), e: 1'b0});
    @(negedge clk);
    checks++;
    if (m1_bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_idle_after: m1_rdy=%b, required 1", m1_bus.ready);
    end
    cyc();
    m1_bus.valid = 1'b0;
    cyc();
    check_drained("timeout");
  endtask

  task automatic test_timeout_race();
    s_bus.ready  = 1'b0;
    m0_bus.addr  = 32'h28;
    m0_bus.valid = 1'b1;
    sb.push_back('{m: 1'b0, d: rom_word(32'h28), e: 1'b0});
    for (int c = 0; c < 5; c++) begin
      if (c == 4) s_bus.ready = 1'b1;
      @(negedge clk);
      checks++;
      if (m0_bus.ready !== (c == 4) || m0_bus.err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_race[%0d]: rdy=%b err=%b, required %b 0", c, m0_bus.ready, m0_bus.err, c == 4);
      end
      cyc();
    end
    m0_bus.valid = 1'b0;
    cyc();
    check_drained("timeout_race");
  endtask

  task automatic test_reset_midlock();
    s_bus.ready  = 1'b0;
    m1_bus.addr  = 32'h3C;
    m1_bus.valid = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_bus.valid, m0_bus.ready, m1_bus.ready, m0_bus.err, m1_bus.err} !== 5'b0) begin
      failures++;
      $display("FAIL midlock_reset: s_valid/m0_rdy/m1_rdy/m0_err/m1_err=%b, required 00000",
               {s_bus.valid, m0_bus.ready, m1_bus.ready, m0_bus.err, m1_bus.err});
    end
    cyc();
    reset_n      = 1'b1;
    s_bus.ready  = 1'b1;
    m0_bus.addr  = 32'h0C;
    m0_bus.valid = 1'b1;
    sb.push_back('{m: 1'b0, d: rom_word(32'h0C), e: 1'b0});
    @(negedge clk);
    checks++;
    if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL midlock_tie: m0_rdy=%b m1_rdy=%b, required 1 0", m0_bus.ready, m1_bus.ready);
    end
    cyc();
    sb.push_back('{m: 1'b1, d: rom_word(32'h3C), e: 1'b0});
    @(negedge clk);
    checks++;
    if (m1_bus.ready !== 1'b1 || s_bus.addr !== 32'h3C) begin
      failures++;
      $display("FAIL midlock_second: m1_rdy=%b s_addr=%h, required 1 0000003c", m1_bus.ready, s_bus.addr);
    end
    cyc();
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    cyc();
    check_drained("reset_midlock");
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    m0_bus.valid = 1'b0;
    m0_bus.addr  = '0;
    m1_bus.valid = 1'b0;
    m1_bus.addr  = '0;
    s_bus.ready  = 1'b0;
    #1;
    test_reset();
    test_zero_wait();
    test_round_robin();
    test_wait_lock();
    test_timeout();
    test_timeout_race();
    test_reset_midlock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-master arbiter that shares one instruction/data memory read port (the fast ROM-style bus with combinational data and ready) between the instruction-fetch unit (master 0) and the load unit (master 1). It sits between the core's fetch and load ports and the single memory slave. Requests are granted round-robin, and a granted transaction is locked until the slave completes it. A per-transaction watchdog terminates hung transactions with an error.

## Interface
- TIMEOUT, 16: number of stalled cycles in a locked transaction before it is forcibly completed with error; legal range 1..255.
- ERR_DATA, 32'h00000013: read data returned on a timed-out transaction (RISC-V NOP).
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- m0_addr  input  32  master 0 (fetch) byte address.
- m0_valid  input  1  master 0 request.
- m0_data  output  32  master 0 read data; valid when m0_ready=1.
- m0_ready  output  1  master 0 transaction complete this cycle.
- m0_err  output  1  master 0 transaction ended by timeout; only meaningful with m0_ready.
- m1_addr, m1_valid, m1_data, m1_ready, m1_err: same as master 0, for master 1 (load).
- s_addr  output  32  slave address, muxed from the granted master.
- s_valid  output  1  slave request.
- s_data  input  32  slave read data.
- s_ready  input  1  slave completes the request this cycle; may be constant 1.

## Operation
- State machine states are IDLE, LOCK0 and LOCK1.
- Register `last` holds the index of the most recently completed master.
- Register `cnt` is a stall counter, $clog2(TIMEOUT+1) bits wide.
- Arbitration happens only in IDLE and is combinational in the same cycle:
  - Only one master valid: that master wins.
  - Both valid: the master not equal to `last` wins.
  - Neither valid: s_valid=0, no state change.
- In IDLE with winner w:
  - s_valid=1 and s_addr=mw_addr.
  - If s_ready=1, mw_ready=1 and mw_data=s_data. On the clock edge, last<=w and the state stays IDLE (zero-wait path).
  - If s_ready=0, the state goes to LOCKw on the edge and cnt<=1.
- In LOCKw:
  - s_valid=1 and s_addr=mw_addr, independent of the other master.
  - If s_ready=1: mw_ready=1, mw_data=s_data. On the edge, last<=w, cnt<=0 and the state returns to IDLE.
  - Else if cnt==TIMEOUT: mw_ready=1, mw_err=1, mw_data=ERR_DATA, and s_valid stays 1 this cycle. On the edge, last<=w, cnt<=0 and the state returns to IDLE.
  - Else cnt<=cnt+1.
- The non-granted master always sees ready=0 and err=0. Its data output is don't-care; drive s_data to both masters.
- Protocol rule for masters: hold valid and addr stable from assertion until ready.
- If a master drops valid while locked, this is a master protocol violation. The arbiter ignores it and the transaction still runs to completion or timeout.
- Reset (reset_n=0 at an edge): state<=IDLE, last<=1 (so master 0 wins the first tie), cnt<=0.
- While reset_n=0, outputs are forced combinationally: s_valid=0, m0_ready=m1_ready=0, m0_err=m1_err=0.
- Asserting reset mid-transaction abandons the pending transaction. No ready is issued for it.

## Timing
- Reset values of all outputs: s_valid=0, m0_ready=m1_ready=0, m0_err=m1_err=0, s_addr=m0_addr, m0_data=m1_data=s_data.
- Latency with a zero-wait slave: 0 cycles; ready is asserted in the same cycle as valid.
- Throughput: one transaction per cycle. With both masters valid continuously, grants alternate 0,1,0,1,…
- Latency with an N-wait slave (s_ready rises in the N-th cycle after the request): ready arrives in that same cycle, provided N ≤ TIMEOUT.
- Timeout: ready and err are asserted in the cycle where cnt==TIMEOUT, i.e. TIMEOUT cycles after the request cycle.
- Timeout with a simultaneous s_ready: s_ready wins, so err=0 and the slave data is returned.
- A new arbitration can occur in the cycle after a LOCK completes, not in the completing cycle.
- Combinational paths exist from m*_valid/m*_addr/s_ready to s_valid/s_addr/m*_ready/m*_data/m*_err. These are intended and match the zero-wait memory.

## Test plan
- Reset, then m0_valid=1 with addr 0x10 against an always-ready slave returning mem[4] → m0_ready=1 in the same cycle, data=mem[4], m1_ready=0.
- Both masters valid for 4 cycles after reset, always-ready slave → grant sequence m0, m1, m0, m1. The s_addr sequence alternates between m0_addr and m1_addr.
- Slave with 3 wait cycles, m1 requests, m0 requests 1 cycle later → m1 is locked and completes in cycle 3, err=0. m0 is granted in the next cycle.
- Slave stuck at s_ready=0, TIMEOUT=4, m0 requests at cycle 0 → m0_ready=1, m0_err=1, data=0x00000013 at cycle 4. The state is IDLE at cycle 5.
- TIMEOUT=4 and s_ready rises exactly at cycle 4 → m0_ready=1, m0_err=0, data=s_data.
- reset_n=0 during LOCK1 at cycle 2 → ready/err/s_valid are 0 during reset. After release, the state is IDLE, and a tie is granted to m0.
